// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit, 8-register pipeline: opcodes, bubble encoding,
// hazard-controller FSM states and the decoded-instruction record.
package pipe_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_RLO  = 4'b0001;
    localparam logic [3:0] OP_RHI  = 4'b0111;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_LD   = 4'b1010;
    localparam logic [3:0] OP_ST   = 4'b1011;
    localparam logic [3:0] OP_BR   = 4'b1100;

    localparam logic [15:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LDSTALL,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       reads_a;
        logic       reads_b;
        logic [2:0] src_a;
        logic [2:0] src_b;
        logic       we;
        logic [2:0] dest;
        logic       is_ld;
        logic       is_br;
        logic [5:0] imm;
    } dec_t;

    function automatic logic is_rtype(input logic [3:0] op);
        return (op >= OP_RLO) && (op <= OP_RHI);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
    logic [15:0] id_instr;
    logic        ex_src_zero;
    logic        halt_req;
    logic        stall;
    logic        branch_taken;
    logic [5:0]  branch_offset_imm;
    logic        flush_id;
    logic        bubble_ex;
    logic        halted;
    logic [7:0]  stall_cnt;
    logic [7:0]  flush_cnt;

    modport master (
        output id_instr, ex_src_zero, halt_req,
        input  stall, branch_taken, branch_offset_imm, flush_id, bubble_ex,
               halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_instr, ex_src_zero, halt_req,
        output stall, branch_taken, branch_offset_imm, flush_id, bubble_ex,
               halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/instr_decode.sv
// Combinational decoder: register read/write usage, load/branch flags and immediate.
module instr_decode
    import pipe_pkg::*;
(
    input  logic [15:0] instr,
    output dec_t        dec
);
    logic [3:0] op;
    assign op = instr[15:12];

    always_comb begin
        dec       = '0;
        dec.src_a = instr[8:6];
        dec.src_b = instr[5:3];
        dec.dest  = instr[11:9];
        dec.imm   = instr[5:0];
        if (is_rtype(op)) begin
            dec.valid   = 1'b1;
            dec.reads_a = 1'b1;
            dec.reads_b = 1'b1;
            dec.we      = 1'b1;
        end else begin
            case (op)
                OP_ADDI: begin
                    dec.valid   = 1'b1;
                    dec.reads_a = 1'b1;
                    dec.we      = 1'b1;
                end
                OP_LD: begin
                    dec.valid   = 1'b1;
                    dec.reads_a = 1'b1;
                    dec.we      = 1'b1;
                    dec.is_ld   = 1'b1;
                end
                OP_ST: begin
                    // The store data register sits in the destination field.
                    dec.valid   = 1'b1;
                    dec.reads_a = 1'b1;
                    dec.reads_b = 1'b1;
                    dec.src_b   = instr[11:9];
                end
                OP_BR: begin
                    dec.valid   = 1'b1;
                    dec.reads_a = 1'b1;
                    dec.is_br   = 1'b1;
                end
                default: dec.valid = 1'b0;
            endcase
        end
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / taken-branch / debug-halt controller for the 5-stage pipeline.
// Optional perf counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter logic [15:0] NOP = pipe_pkg::NOP
) (
    input  logic                     clk,
    input  logic                     rst,
    pipe_hazard_ctrl_if.slave        bus
);
    dec_t       id_dec;
    state_t     state_reg, state_next;
    logic       ex_valid_reg, ex_we_reg, ex_ld_reg, ex_br_reg;
    logic [2:0] ex_dest_reg;
    logic [5:0] ex_off_reg;
    logic       halted_reg;
    logic       id_valid, hit_a, hit_b, load_use, br_taken;
    logic       stall_c, taken_c, flush_c, bubble_c;
    logic [5:0] off_c;

    instr_decode u_id_decode (
        .instr (bus.id_instr),
        .dec   (id_dec)
    );

    assign id_valid = id_dec.valid && (bus.id_instr != NOP);
    assign hit_a    = id_dec.reads_a && (id_dec.src_a == ex_dest_reg);
    assign hit_b    = id_dec.reads_b && (id_dec.src_b == ex_dest_reg);
    // R0 is hard-wired zero, so a load into it never has to be waited on.
    assign load_use = ex_valid_reg && ex_ld_reg && ex_we_reg && (ex_dest_reg != 3'd0)
                      && id_valid && (hit_a || hit_b);
    assign br_taken = ex_valid_reg && ex_br_reg && bus.ex_src_zero;

    always_comb begin
        state_next = state_reg;
        stall_c    = 1'b0;
        taken_c    = 1'b0;
        flush_c    = 1'b0;
        bubble_c   = 1'b0;
        off_c      = 6'd0;
        case (state_reg)
            ST_RUN: begin
                if (br_taken) begin
                    taken_c  = 1'b1;
                    off_c    = ex_off_reg;
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (load_use) begin
                    stall_c    = 1'b1;
                    bubble_c   = 1'b1;
                    state_next = ST_LDSTALL;
                end else if (bus.halt_req) begin
                    state_next = ST_HALT;
                end
            end
            ST_LDSTALL: begin
                state_next = bus.halt_req ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                if (!bus.halt_req) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_RUN;
            halted_reg   <= 1'b0;
            ex_valid_reg <= 1'b0;
            ex_we_reg    <= 1'b0;
            ex_ld_reg    <= 1'b0;
            ex_br_reg    <= 1'b0;
            ex_dest_reg  <= 3'd0;
            ex_off_reg   <= 6'd0;
        end else begin
            state_reg  <= state_next;
            halted_reg <= (state_reg == ST_HALT);
            if (!stall_c && !bubble_c) begin
                ex_valid_reg <= id_valid;
                ex_we_reg    <= id_dec.we;
                ex_ld_reg    <= id_dec.is_ld;
                ex_br_reg    <= id_dec.is_br;
                ex_dest_reg  <= id_dec.dest;
                ex_off_reg   <= id_dec.imm;
            end else begin
                ex_valid_reg <= 1'b0;
                ex_we_reg    <= 1'b0;
                ex_ld_reg    <= 1'b0;
                ex_br_reg    <= 1'b0;
                ex_dest_reg  <= 3'd0;
                ex_off_reg   <= 6'd0;
            end
        end
    end

    assign bus.stall             = stall_c;
    assign bus.branch_taken      = taken_c;
    assign bus.branch_offset_imm = off_c;
    assign bus.flush_id          = flush_c;
    assign bus.bubble_ex         = bubble_c;
    assign bus.halted            = halted_reg;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [7:0] stall_cnt_reg, flush_cnt_reg;

    // Halt stalls are deliberate, so only hazard stalls are counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_reg <= 8'd0;
            flush_cnt_reg <= 8'd0;
        end else begin
            if (stall_c && (state_reg != ST_HALT) && (stall_cnt_reg != 8'hFF))
                stall_cnt_reg <= stall_cnt_reg + 8'd1;
            if (taken_c && (flush_cnt_reg != 8'hFF))
                flush_cnt_reg <= flush_cnt_reg + 8'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_reg;
    assign bus.flush_cnt = flush_cnt_reg;
`else
    assign bus.stall_cnt = 8'h00;
    assign bus.flush_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl plus hand-written halt/reset sequences.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   exp_scnt = 0;
    int   exp_fcnt = 0;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic        sz;
        logic        hr;
        logic        st;
        logic        bt;
        logic [5:0]  off;
        logic        fl;
        logic        bb;
        logic        hd;
        logic        hlt;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [15:0] instr, input logic sz, input logic hr);
        @(negedge clk);
        bus.id_instr    = instr;
        bus.ex_src_zero = sz;
        bus.halt_req    = hr;
        #1;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, ".stall_cnt"}, {8'h00, bus.stall_cnt}, PERF ? 16'(exp_scnt) : 16'h0000);
        check({tag, ".flush_cnt"}, {8'h00, bus.flush_cnt}, PERF ? 16'(exp_fcnt) : 16'h0000);
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".stall"},  {15'd0, bus.stall},             {15'd0, v.st});
        check({tag, ".taken"},  {15'd0, bus.branch_taken},      {15'd0, v.bt});
        check({tag, ".off"},    {10'd0, bus.branch_offset_imm}, {10'd0, v.off});
        check({tag, ".flush"},  {15'd0, bus.flush_id},          {15'd0, v.fl});
        check({tag, ".bubble"}, {15'd0, bus.bubble_ex},         {15'd0, v.bb});
        check({tag, ".halted"}, {15'd0, bus.halted},            {15'd0, v.hd});
        check_cnts(tag);
    endtask

    initial begin
        vec_t v;
        bit   found;
        // instr, ex_src_zero, halt_req | stall, taken, off, flush, bubble, halted, halt-stall
        vq.push_back('{16'hAECE, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0}); // LD R7
        vq.push_back('{16'h17B8, 0, 0, 1, 0, 6'h00, 0, 1, 0, 0}); // ADD R3=R6+R7: load-use
        vq.push_back('{16'h17B8, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0}); // held instr advances
        vq.push_back('{16'h0000, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0});
        vq.push_back('{16'hA000, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0}); // LD R0
        vq.push_back('{16'h1200, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0}); // ADD R1=R0+R0: exempt
        vq.push_back('{16'hC041, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0}); // BR R1,+1 (EX not a BR)
        vq.push_back('{16'h0000, 1, 0, 0, 1, 6'h01, 1, 1, 0, 0}); // taken
        vq.push_back('{16'h0000, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0});
        vq.push_back('{16'hC07B, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0}); // BR R1,-5
        vq.push_back('{16'h0000, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0}); // not taken
        vq.push_back('{16'h0000, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0});
        vq.push_back('{16'hA400, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0}); // LD R2
        vq.push_back('{16'hB400, 0, 0, 1, 0, 6'h00, 0, 1, 0, 0}); // ST reads R2 in [11:9]
        vq.push_back('{16'hB400, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0});
        vq.push_back('{16'h0000, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0});
        vq.push_back('{16'hAA00, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0}); // LD R5
        vq.push_back('{16'h9340, 0, 0, 1, 0, 6'h00, 0, 1, 0, 0}); // ADDI R1,R5
        vq.push_back('{16'h9340, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0});
        vq.push_back('{16'h0000, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0});
        vq.push_back('{16'hA800, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0}); // LD R4
        vq.push_back('{16'h1370, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0}); // ADD R1=R5+R6: independent
        vq.push_back('{16'hC03B, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0}); // BR R0,-5
        vq.push_back('{16'h0000, 1, 0, 0, 1, 6'h3B, 1, 1, 0, 0}); // taken, negative offset
        vq.push_back('{16'h0000, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0});
        vq.push_back('{16'h0000, 0, 1, 0, 0, 6'h00, 0, 0, 0, 0}); // RUN -> HALT, no outputs
        vq.push_back('{16'h0000, 0, 1, 1, 0, 6'h00, 0, 1, 0, 1}); // first HALT cycle
        vq.push_back('{16'h0000, 0, 1, 1, 0, 6'h00, 0, 1, 1, 1});
        vq.push_back('{16'h0000, 0, 0, 1, 0, 6'h00, 0, 1, 1, 1}); // release seen, leave next edge
        vq.push_back('{16'h0000, 0, 0, 0, 0, 6'h00, 0, 0, 1, 0});
        vq.push_back('{16'h0000, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0});
        vq.push_back('{16'hA600, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0}); // LD R3
        vq.push_back('{16'h12C0, 0, 1, 1, 0, 6'h00, 0, 1, 0, 0}); // load-use beats halt
        vq.push_back('{16'h12C0, 0, 1, 0, 0, 6'h00, 0, 0, 0, 0}); // LDSTALL -> HALT
        vq.push_back('{16'h0000, 0, 1, 1, 0, 6'h00, 0, 1, 0, 1});
        vq.push_back('{16'h0000, 0, 0, 1, 0, 6'h00, 0, 1, 1, 1});
        vq.push_back('{16'h0000, 0, 0, 0, 0, 6'h00, 0, 0, 1, 0});
        vq.push_back('{16'h0000, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0});

        // Reset held for two edges.
        rst = 1'b0;
        bus.id_instr = 16'h0000;
        bus.ex_src_zero = 1'b0;
        bus.halt_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        v = '{16'h0000, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0};
        check_all("reset", v);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].instr, vq[i].sz, vq[i].hr);
            check_all($sformatf("vec%0d", i), vq[i]);
            $display("vec%0d instr=%h sz=%b hr=%b -> stall=%b taken=%b off=%h flush=%b bubble=%b halted=%b",
                     i, vq[i].instr, vq[i].sz, vq[i].hr, bus.stall, bus.branch_taken,
                     bus.branch_offset_imm, bus.flush_id, bus.bubble_ex, bus.halted);
            if (vq[i].st && !vq[i].hlt) exp_scnt++;
            if (vq[i].bt) exp_fcnt++;
        end

        // Taken branch with halt requested in the same cycle: redirect wins, HALT follows.
        drive(16'hC041, 1'b0, 1'b0);
        drive(16'h0000, 1'b1, 1'b1);
        v = '{16'h0000, 1, 1, 0, 1, 6'h01, 1, 1, 0, 0};
        check_all("br_halt.redirect", v);
        $display("br_halt redirect taken=%b off=%h flush=%b", bus.branch_taken, bus.branch_offset_imm, bus.flush_id);
        exp_fcnt++;
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            drive(16'h0000, 1'b0, 1'b1);
            if (bus.stall) found = 1'b1;
        end
        check("br_halt.entered", {15'd0, found}, 16'd1);
        check("br_halt.halted_first", {15'd0, bus.halted}, 16'd0);
        check("br_halt.bubble_first", {15'd0, bus.bubble_ex}, 16'd1);
        drive(16'h0000, 1'b0, 1'b1);
        check("br_halt.halted_next", {15'd0, bus.halted}, 16'd1);
        check("br_halt.stall_next", {15'd0, bus.stall}, 16'd1);
        drive(16'h0000, 1'b0, 1'b0);
        check("br_halt.release_cycle", {15'd0, bus.stall}, 16'd1);
        drive(16'h0000, 1'b0, 1'b0);
        check("br_halt.run_again", {15'd0, bus.stall}, 16'd0);
        check_cnts("br_halt");
        $display("br_halt sequence done stall_cnt=%0d flush_cnt=%0d", bus.stall_cnt, bus.flush_cnt);

        // Reset while halted returns to RUN and clears the counters.
        drive(16'h0000, 1'b0, 1'b1);
        drive(16'h0000, 1'b0, 1'b1);
        check("rst_halt.in_halt", {15'd0, bus.stall}, 16'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.halt_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_scnt = 0;
        exp_fcnt = 0;
        check("rst_halt.stall", {15'd0, bus.stall}, 16'd0);
        check("rst_halt.halted", {15'd0, bus.halted}, 16'd0);
        check_cnts("rst_halt");
        $display("rst_halt stall=%b halted=%b", bus.stall, bus.halted);

        // Reset discards a load sitting in EX: its consumer must not stall.
        drive(16'hAECE, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.id_instr = 16'h17B8;
        #1;
        check("rst_ex.no_stall", {15'd0, bus.stall}, 16'd0);
        check("rst_ex.no_bubble", {15'd0, bus.bubble_ex}, 16'd0);
        $display("rst_ex stall=%b bubble=%b", bus.stall, bus.bubble_ex);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
